// File: rtl/dff_share_arbiter.sv
// dff_share_arbiter: round-robin owner selection for a single shared WIDTH-bit register.
// Each edge picks at most one requester, loads its data into the register and reports
// the owner. Defining ARB_LOCK_EN adds a bounded lock: the owner may keep the register
// for up to MAX_HOLD consecutive cycles. Without it, lock_i is ignored and every cycle
// is a fresh round-robin decision.
module dff_share_arbiter #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ*WIDTH-1:0]    wdata_i,
    input  logic [NREQ-1:0]          lock_i,
    output logic [NREQ-1:0]          gnt_o,
    output logic [$clog2(NREQ)-1:0]  owner_o,
    output logic [WIDTH-1:0]         q_o,
    output logic                     q_valid_o
);

    localparam int unsigned OW = $clog2(NREQ);

`ifdef ARB_LOCK_EN
    typedef enum logic [1:0] {StIdle, StGrant, StHold} state_e;
    localparam logic [3:0] MaxHold = 4'(MAX_HOLD);
`else
    typedef enum logic [0:0] {StIdle, StGrant} state_e;
`endif

    state_e            state_q, state_d;
    logic [OW-1:0]     ptr_q, ptr_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic              q_valid_q, q_valid_d;

`ifdef ARB_LOCK_EN
    logic [3:0]        hold_cnt_q, hold_cnt_d;
    logic              hold_ok;
`else
    logic              unused_lock;
    assign unused_lock = ^lock_i;
`endif

    logic              any_req;
    logic              found;
    logic [OW-1:0]     win;
    logic [OW-1:0]     win_next;

    // Round-robin search starting at ptr_q; the previous owner sits at the lowest priority.
    always_comb begin
        int unsigned idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr_q) + k) % NREQ;
            if (!found && req_i[OW'(idx)]) begin
                found = 1'b1;
                win   = OW'(idx);
            end
        end
        any_req  = found;
        win_next = OW'((32'(win) + 1) % NREQ);
    end

`ifdef ARB_LOCK_EN
    // The owner keeps the register only while it still requests and the bound is not hit.
    always_comb begin
        hold_ok = (state_q != StIdle) && req_i[owner_q] && lock_i[owner_q] &&
                  (hold_cnt_q < MaxHold);
    end
`endif

    // Next-state: hold the current owner, grant a new winner, or fall back to idle.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        gnt_d     = gnt_q;
        q_d       = q_q;
        q_valid_d = q_valid_q;
`ifdef ARB_LOCK_EN
        hold_cnt_d = hold_cnt_q;
        if (hold_ok) begin
            state_d    = StHold;
            q_d        = wdata_i[owner_q*WIDTH +: WIDTH];
            q_valid_d  = 1'b1;
            hold_cnt_d = hold_cnt_q + 4'd1;
        end else
`endif
        if (any_req) begin
            state_d   = StGrant;
            owner_d   = win;
            gnt_d     = {{(NREQ-1){1'b0}}, 1'b1} << win;
            q_d       = wdata_i[win*WIDTH +: WIDTH];
            q_valid_d = 1'b1;
            ptr_d     = win_next;
`ifdef ARB_LOCK_EN
            hold_cnt_d = 4'd1;
`endif
        end else begin
            // q keeps its last value; only the grant and valid flag drop.
            state_d   = StIdle;
            gnt_d     = '0;
            q_valid_d = 1'b0;
`ifdef ARB_LOCK_EN
            hold_cnt_d = '0;
`endif
        end
    end

    // State and output registers; reset clears outputs without waiting for a clock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            owner_q    <= '0;
            gnt_q      <= '0;
            q_q        <= '0;
            q_valid_q  <= 1'b0;
`ifdef ARB_LOCK_EN
            hold_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            gnt_q      <= gnt_d;
            q_q        <= q_d;
            q_valid_q  <= q_valid_d;
`ifdef ARB_LOCK_EN
            hold_cnt_q <= hold_cnt_d;
`endif
        end
    end

    assign gnt_o     = gnt_q;
    assign owner_o   = owner_q;
    assign q_o       = q_q;
    assign q_valid_o = q_valid_q;

endmodule

// File: doc/dff_share_arbiter.md
# dff_share_arbiter

Round-robin arbiter that shares a single WIDTH-bit edge-triggered storage register among NREQ requesters. Each cycle it selects at most one requesting source, loads that source's data into the shared register and reports the owner. An optional bounded lock lets one requester hold the register for back-to-back updates. It sits in front of the team's plain D flip-flop storage and is the only writer of the shared register.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, shared register width
- MAX_HOLD, 4, maximum consecutive cycles a locked requester may own the register (1..15)
- clk  in  1  single clock, all state on posedge
- rst_n  in  1  asynchronous, active-low reset
- req  in  NREQ  request vector, bit i = requester i
- wdata  in  NREQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]
- lock  in  NREQ  bit i requests continued ownership; meaningful only while gnt[i]=1
- gnt  out  NREQ  registered one-hot grant, or all-zero
- owner  out  $clog2(NREQ)  index of current grantee; valid when q_valid=1
- q  out  WIDTH  shared register contents
- q_valid  out  1  high in the cycle after a load

## Operation
- Reset values: gnt=0, owner=0, q=0, q_valid=0, ptr=0, hold_cnt=0, state=IDLE.
- ptr = highest-priority index. Search order: ptr, ptr+1, … mod NREQ.
- States:
  - IDLE: gnt=0. If any req, go to GRANT with the round-robin winner w.
  - GRANT: gnt=one-hot(w), owner=w, q loaded with wdata[w], q_valid=1, ptr←(w+1) mod NREQ, hold_cnt←1.
  - HOLD: same outputs as GRANT; q reloads from wdata[owner] each cycle; hold_cnt increments.
- Transitions out of GRANT/HOLD, evaluated at each edge:
  - req[owner]&lock[owner] and hold_cnt<MAX_HOLD: go to HOLD with the same owner.
  - Otherwise, if any req: go to GRANT with a new round-robin winner from ptr. The former owner is eligible but has lowest priority.
  - Otherwise: go to IDLE. On that edge gnt→0 and q_valid→0; q retains its value.
- Lock on the cycle hold_cnt==MAX_HOLD is ignored and arbitration proceeds normally. A sole requester may win again via GRANT, which restarts hold_cnt at 1.
- req deasserting mid-grant: the grant is dropped at the next edge and the requester's data for that cycle is not loaded.
- lock with req low, or lock on a non-owner: ignored.
- q changes only on an edge where a grant is issued or held. It never changes while gnt=0.

## Timing
- Latency: req sampled at edge t → gnt, owner, q and q_valid all valid after edge t (one cycle).
- wdata is sampled on the same edge as the grant decision. Requesters hold wdata stable while req is high.
- Back-to-back grants to different requesters need no idle gap.
- Maximum continuous ownership under contention: MAX_HOLD cycles. Any other requesting source waits at most (NREQ-1)*MAX_HOLD cycles.
- Asynchronous reset mid-hold: all outputs clear immediately, without waiting for clk. The first edge after rst_n rises arbitrates from ptr=0.

## Configuration
- ARB_LOCK_EN defined: lock input, HOLD state and hold_cnt are present as described above.
- ARB_LOCK_EN undefined:
  - lock port remains but is ignored.
  - No HOLD state and no hold_cnt; every cycle is a fresh GRANT/IDLE round-robin decision.
  - A sole continuous requester is regranted every cycle.

## Test plan
- Reset: drive rst_n=0 mid-grant with req=4'b1111 → gnt=0, q=0, q_valid=0, owner=0 immediately, without a clk edge. First edge after release grants requester 0.
- Rotation: req=4'b1111, wdata_i=8'h10+i, lock=0 → gnt sequence 0001,0010,0100,1000,0001. q sequence 10,11,12,13,10. q_valid held at 1.
- Skip/idle: req=4'b1010 → grants 1,3,1. Then req=0 → gnt=0 and q_valid=0 next cycle while q holds its last value.
- Lock bound (ARB_LOCK_EN, MAX_HOLD=4): req=4'b0011, lock[0]=1 with requester 0 granted, wdata0 incrementing → owner 0 for exactly 4 cycles with q tracking wdata0, then owner 1.
- Lock ignored: lock[2]=1 while owner=1 and req=4'b0110 → next grant goes to 2 via normal rotation only. With ARB_LOCK_EN undefined, the lock-bound scenario instead alternates 0,1,0,1.
- Mid-grant drop: owner 3 with lock=1, then req[3]→0 → gnt[3] clears at the next edge and q does not load that cycle's wdata3.
